text_line_writer: RTL and testbench
===================================

TEXT_LINE_WRITER -- requirements
Module: text_line_writer

Interface
REQ-001 SHALL have parameter LINE_LEN, default 16, meaning characters per line; it is a power of two, 2..128; CW = log2(LINE_LEN).
REQ-002 SHALL have parameter FILL_CHAR, default 7'h20, meaning the blank character code written by clear and backspace.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-007 SHALL have port cmd_op  input  2  command opcode: 00 PUT, 01 CLEAR, 10 SETCUR, 11 BKSP.
REQ-008 SHALL have port cmd_data  input  7  character code for PUT; cursor position for SETCUR; ignored otherwise.
REQ-009 SHALL have port char_xy  input  8  read address from the renderer; column = char_xy[CW-1:0].
REQ-010 SHALL have port char_code  output  7  registered character at char_xy.
REQ-011 SHALL have port cursor  output  CW  current write column.
REQ-012 SHALL have port busy  output  1  high while a clear sweep runs.
REQ-013 SHALL have port wrapped  output  1  one-cycle pulse when PUT wraps the cursor.

Function
REQ-014 SHALL hold a LINE_LEN x 7-bit line buffer with one write port and one synchronous read port.
REQ-015 SHALL implement FSM states CLEAR and IDLE.
REQ-016 SHALL drive cmd_ready = 1 only in IDLE; busy = 1 only in CLEAR; both are combinational from state.
REQ-017 CLEAR SHALL write FILL_CHAR to one column per cycle, starting at index 0 and ascending. After writing column LINE_LEN-1 it SHALL move to IDLE, taking exactly LINE_LEN cycles.
REQ-018 Read path: char_code SHALL update each cycle to buffer[char_xy[CW-1:0]], with 1-cycle latency.
REQ-019 Read path: if char_xy[7:CW] != 0, or the state is CLEAR, char_code SHALL be FILL_CHAR.
REQ-020 A write and a read to the same column in the same cycle SHALL return the old value (read-before-write).
REQ-021 PUT SHALL write cmd_data to buffer[cursor] and advance the cursor by 1. From LINE_LEN-1 the cursor SHALL go to 0 with wrapped = 1 for exactly the next cycle.
REQ-022 CLEAR command SHALL set cursor to 0 and enter the CLEAR state on the next edge.
REQ-023 SETCUR SHALL set cursor to cmd_data when cmd_data < LINE_LEN, else to LINE_LEN-1 (saturate, no wrap); it SHALL make no buffer write.
REQ-024 BKSP at cursor > 0 SHALL decrement the cursor and write FILL_CHAR to buffer[cursor-1].
REQ-025 BKSP at cursor = 0 SHALL make no change and no write; wrapped stays 0.
REQ-026 The cursor output SHALL update on the edge that accepts the command.
REQ-027 A written character SHALL be readable on char_code 1 cycle after that edge, given char_xy is held.
REQ-028 Commands back-to-back in IDLE SHALL be accepted one per cycle with no bubbles.
REQ-029 cmd_valid without cmd_ready SHALL have no effect. cmd_op and cmd_data are sampled only on acceptance.
REQ-030 wrapped SHALL be 0 in every cycle except the cycle following a wrapping PUT.

Reset
REQ-031 While rst = 0, outputs SHALL be: cursor = 0, char_code = 0, wrapped = 0, busy = 1, cmd_ready = 0, state = CLEAR, clear index = 0.
REQ-032 After rst rises, the block SHALL perform a full clear sweep (LINE_LEN cycles) before the first cmd_ready = 1; buffer contents are not reset directly.
REQ-033 Reset asserted mid-sweep or mid-stream SHALL abort immediately to the REQ-031 values and restart the sweep after release.

Verification
REQ-034 Release reset with LINE_LEN=16 -> busy=1 for 16 cycles, then cmd_ready=1; all 16 columns read 7'h20.
REQ-035 PUT 'A','B' (7'h41,7'h42) on consecutive cycles -> cursor 0->1->2; col0=7'h41 and col1=7'h42 one cycle after each write; char_xy=8'h10 -> 7'h20.
REQ-036 SETCUR 15, then PUT 7'h5A -> col15=7'h5A, cursor=0, wrapped=1 for one cycle only; SETCUR 40 -> cursor=15.
REQ-037 At cursor 0, BKSP -> no change; at cursor 2 after REQ-035, BKSP -> cursor=1 and col1=7'h20.
REQ-038 CLEAR command with cmd_valid held high -> cmd_ready=0 for 16 cycles, char_code=7'h20 throughout, cursor=0; a held PUT is accepted on the first IDLE cycle.
REQ-039 Assert rst at sweep cycle 7, hold it, then release -> REQ-031 values while held; a full 16-cycle sweep follows release.

Source files
------------

// File: rtl/text_line_writer.sv
// text_line_writer: one-line character buffer written by a small command stream
//   (PUT / CLEAR / SETCUR / BKSP) and read back by a renderer through a registered port.
// Latency: commands take effect on the accepting edge; char_code is 1 cycle after char_xy.
// Backpressure: cmd_ready is low for the LINE_LEN-cycle clear sweep (after reset or CLEAR).
// Ports:
//   clk, rst         - single rising-edge clock, asynchronous active-low reset
//   cmd_valid/ready  - command handshake; cmd_op, cmd_data sampled only on acceptance
//   char_xy          - renderer read address (column in low CW bits, upper bits must be 0)
//   char_code        - registered character at char_xy
//   cursor           - current write column
//   busy             - high during the clear sweep
//   wrapped          - one-cycle pulse after a PUT that wraps the cursor to 0
module text_line_writer #(
  parameter int         LINE_LEN  = 16,
  parameter logic [6:0] FILL_CHAR = 7'h20,
  localparam int        CW        = $clog2(LINE_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [6:0]    cmd_data,
  input  logic [7:0]    char_xy,
  output logic [6:0]    char_code,
  output logic [CW-1:0] cursor,
  output logic          busy,
  output logic          wrapped
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  localparam logic [1:0] OP_PUT    = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SETCUR = 2'b10;
  localparam logic [1:0] OP_BKSP   = 2'b11;

  localparam logic [CW-1:0] LAST_COL = CW'(LINE_LEN - 1);
  localparam logic [7:0]    LEN8     = 8'(LINE_LEN);

  logic [0:0]    r_state;
  logic [CW-1:0] r_clr_idx;
  logic [CW-1:0] r_cursor;
  logic          r_wrapped;
  logic [6:0]    r_char_code;
  logic [6:0]    r_buf [LINE_LEN];

  logic          w_accept;
  logic          w_we;
  logic [CW-1:0] w_waddr;
  logic [6:0]    w_wdata;
  logic [CW-1:0] w_rd_col;
  logic          w_rd_out_of_line;
  logic          w_setcur_in_range;

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_CLEAR);
  assign w_accept  = cmd_valid && cmd_ready;

  assign cursor    = r_cursor;
  assign wrapped   = r_wrapped;
  assign char_code = r_char_code;

  assign w_rd_col          = char_xy[CW-1:0];
  assign w_rd_out_of_line  = ((char_xy >> CW) != 8'd0);
  assign w_setcur_in_range = ({1'b0, cmd_data} < LEN8);

  // Single write port shared by the clear sweep and the command path.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_clr_idx;
    w_wdata = FILL_CHAR;
    if (r_state == ST_CLEAR) begin
      w_we = 1'b1;
    end else if (w_accept) begin
      case (cmd_op)
        OP_PUT: begin
          w_we    = 1'b1;
          w_waddr = r_cursor;
          w_wdata = cmd_data;
        end
        OP_BKSP: begin
          w_we    = (r_cursor != '0);
          w_waddr = r_cursor - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Buffer storage is deliberately not reset; the post-reset sweep initialises it.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_buf[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_CLEAR;
      r_clr_idx   <= '0;
      r_cursor    <= '0;
      r_wrapped   <= 1'b0;
      r_char_code <= 7'h00;
    end else begin
      r_wrapped <= 1'b0;

      // Nonblocking read of r_buf gives read-before-write on a same-column collision.
      if (w_rd_out_of_line || (r_state == ST_CLEAR)) begin
        r_char_code <= FILL_CHAR;
      end else begin
        r_char_code <= r_buf[w_rd_col];
      end

      if (r_state == ST_CLEAR) begin
        r_clr_idx <= r_clr_idx + 1'b1;
        if (r_clr_idx == LAST_COL) begin
          r_state <= ST_IDLE;
        end
      end else if (w_accept) begin
        case (cmd_op)
          OP_PUT: begin
            r_cursor <= r_cursor + 1'b1;
            if (r_cursor == LAST_COL) begin
              r_wrapped <= 1'b1;
            end
          end
          OP_CLEAR: begin
            r_cursor  <= '0;
            r_clr_idx <= '0;
            r_state   <= ST_CLEAR;
          end
          OP_SETCUR: begin
            r_cursor <= w_setcur_in_range ? cmd_data[CW-1:0] : LAST_COL;
          end
          OP_BKSP: begin
            if (r_cursor != '0) begin
              r_cursor <= r_cursor - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_line_writer.sv
// tb_text_line_writer: directed and random command streams against a line-buffer model.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: the model tracks the remaining clear-sweep length and accepts only when it is zero.
module tb_text_line_writer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [6:0] cmd_data;
  logic [7:0] char_xy;
  logic [6:0] char_code;
  logic [3:0] cursor;
  logic       busy;
  logic       wrapped;

  int checks;
  int errors;

  // Reference model: line contents, cursor, remaining sweep cycles, wrap pulse.
  logic [6:0] m_buf [16];
  int         m_busy;
  int         m_cur;
  bit         m_wrap;

  text_line_writer #(.LINE_LEN(16), .FILL_CHAR(7'h20)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .char_xy   (char_xy),
    .char_code (char_code),
    .cursor    (cursor),
    .busy      (busy),
    .wrapped   (wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] exp_char);
    chk({tag, ".cursor"},  {4'b0, cursor},    8'(m_cur));
    chk({tag, ".wrapped"}, {7'b0, wrapped},   {7'b0, m_wrap});
    chk({tag, ".busy"},    {7'b0, busy},      {7'b0, (m_busy > 0)});
    chk({tag, ".ready"},   {7'b0, cmd_ready}, {7'b0, (m_busy == 0)});
    chk({tag, ".char"},    {1'b0, char_code}, exp_char);
  endtask

  // Advance one clock: predict from current inputs, then compare after the edge.
  task automatic cycle(input string tag);
    logic [7:0] exp_char;
    logic [3:0] col;
    bit         acc;
    col = char_xy[3:0];
    if ((char_xy >> 4) != 8'd0 || m_busy > 0) exp_char = 8'h20;
    else                                      exp_char = {1'b0, m_buf[col]};
    acc    = (m_busy == 0) && cmd_valid;
    m_wrap = 1'b0;
    if (m_busy > 0) begin
      m_buf[16 - m_busy] = 7'h20;
      m_busy--;
    end else if (acc) begin
      case (cmd_op)
        2'b00: begin
          m_buf[m_cur] = cmd_data;
          if (m_cur == 15) begin m_cur = 0; m_wrap = 1'b1; end
          else m_cur++;
        end
        2'b01: begin m_cur = 0; m_busy = 16; end
        2'b10: m_cur = (int'(cmd_data) < 16) ? int'(cmd_data) : 15;
        default: if (m_cur > 0) begin m_cur--; m_buf[m_cur] = 7'h20; end
      endcase
    end
    @(posedge clk);
    #1;
    chk_all(tag, exp_char);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, ".cursor"},  {4'b0, cursor},    8'h00);
    chk({tag, ".char"},    {1'b0, char_code}, 8'h00);
    chk({tag, ".wrapped"}, {7'b0, wrapped},   8'h00);
    chk({tag, ".busy"},    {7'b0, busy},      8'h01);
    chk({tag, ".ready"},   {7'b0, cmd_ready}, 8'h00);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #2;
    m_busy = 16;
    m_cur  = 0;
    m_wrap = 1'b0;
    reset_check({tag, ".assert"});
    repeat (2) @(posedge clk);
    #1;
    reset_check({tag, ".held"});
    rst = 1'b1;
  endtask

  task automatic put_cmd(input logic [1:0] op, input logic [6:0] data, input string tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cycle(tag);
  endtask

  task automatic idle(input logic [7:0] xy, input string tag);
    cmd_valid = 1'b0;
    char_xy   = xy;
    cycle(tag);
  endtask

  initial begin
    int r;
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 7'h00;
    char_xy   = 8'h00;
    for (int i = 0; i < 16; i++) m_buf[i] = 7'h00;

    @(posedge clk);
    #1;
    do_reset("rst0");

    // Post-reset sweep then every column reads blank.
    repeat (16) cycle("sweep0");
    for (int i = 0; i < 16; i++) idle(8'(i), "readall");

    // PUT 'A','B' back to back, read back, out-of-line address.
    char_xy = 8'h00;
    put_cmd(2'b00, 7'h41, "putA");
    put_cmd(2'b00, 7'h42, "putB");
    idle(8'h01, "rdB");
    idle(8'h10, "rdhi");

    // BKSP at cursor 2.
    put_cmd(2'b11, 7'h00, "bksp2");
    idle(8'h01, "rdbk");
    idle(8'h00, "rdA");

    // Wrap at the last column, then saturating SETCUR.
    put_cmd(2'b10, 7'd15, "set15");
    put_cmd(2'b00, 7'h5A, "putwrap");
    idle(8'h0F, "rd15");
    idle(8'h0F, "afterwrap");
    put_cmd(2'b10, 7'd40, "set40");
    idle(8'h0F, "sat");

    // BKSP at cursor 0 is a no-op.
    put_cmd(2'b10, 7'd0, "set0");
    put_cmd(2'b11, 7'h00, "bksp0a");
    put_cmd(2'b11, 7'h00, "bksp0b");
    idle(8'h00, "rd0");

    // CLEAR with a PUT held behind it.
    char_xy = 8'h00;
    put_cmd(2'b01, 7'h00, "clear");
    repeat (17) put_cmd(2'b00, 7'h33, "heldput");
    idle(8'h00, "rdheld");

    // Reset at sweep cycle 7.
    put_cmd(2'b01, 7'h00, "clear2");
    repeat (6) idle(8'h02, "partial");
    do_reset("rst7");
    repeat (16) cycle("sweep1");
    idle(8'h00, "rdpost");

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      r         = $urandom_range(0, 19);
      cmd_op    = (r == 0) ? 2'b01 : (r < 10) ? 2'b00 : (r < 15) ? 2'b10 : 2'b11;
      cmd_data  = 7'($urandom_range(0, 127));
      cmd_valid = ($urandom_range(0, 3) != 0);
      char_xy   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                              : 8'($urandom_range(0, 15));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
